// File: rtl/arbiter_4way.sv
// Four-way round-robin arbiter with registered one-hot grant and a Mux4Way select.
// Optional per-holder grant quantum enabled by defining ARB4_QUANTUM_EN.
module arbiter_4way #(
  parameter int unsigned QUANTUM = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  // Handshake: req[i] is a level request; gnt is registered, so req sampled at
  // edge N shows up on gnt/sel/busy only after edge N. A holder keeps the grant
  // while its req stays high; dropping req releases it at the next edge.

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] next_idx;
  logic [3:0] others;
  logic       do_grant;
  logic       go_idle;

  // First asserted requester searching upward from start, wrapping 3->0.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // ptr always holds the current/last holder, so one search origin serves all cases.
  assign next_idx = rr_pick(req, ptr + 2'd1);
  assign others   = req & ~gnt;

`ifdef ARB4_QUANTUM_EN
  localparam logic [3:0] QUANTUM_W = 4'(QUANTUM);

  logic [3:0] cnt;
  logic       quantum_hit;

  assign quantum_hit = (cnt == QUANTUM_W);
`endif

  always_comb begin
    do_grant = 1'b0;
    go_idle  = 1'b0;
    case (state)
      IDLE: do_grant = |req;
      GRANT: begin
        if (!req[ptr]) begin
          do_grant = |req;
          go_idle  = ~|req;
        end
`ifdef ARB4_QUANTUM_EN
        else if (quantum_hit && |others) begin
          do_grant = 1'b1;
        end
`endif
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      busy  <= 1'b0;
      ptr   <= 2'd3;
      sel   <= 2'd0;
    end else if (do_grant) begin
      state <= GRANT;
      gnt   <= 4'b0001 << next_idx;
      busy  <= 1'b1;
      ptr   <= next_idx;
      sel   <= next_idx;
    end else if (go_idle) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      busy  <= 1'b0;
    end
  end

`ifdef ARB4_QUANTUM_EN
  // Count granted cycles; a full quantum with no contender restarts the count.
  always_ff @(posedge clk) begin
    if (reset || go_idle) begin
      cnt <= 4'd0;
    end else if (do_grant) begin
      cnt <= 4'd1;
    end else if (state == GRANT) begin
      cnt <= quantum_hit ? 4'd1 : cnt + 4'd1;
    end
  end
`else
  logic unused_others;
  assign unused_others = ^others;
`endif

endmodule

// File: tb/tb_arbiter_4way.sv
// Self-checking bench for arbiter_4way: directed vector table, quantum/no-quantum
// sequences and randomized traffic against a behavioural round-robin model.
module tb_arbiter_4way;

  localparam int QUANTUM = 4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // model state: holder index (-1 when idle), last granted index, sel, run length
  int m_holder;
  int m_last;
  int m_sel;
  int m_run;

  arbiter_4way #(.QUANTUM(QUANTUM)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int next_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_grant(input int h);
    m_holder = h;
    m_last   = h;
    m_sel    = h;
    m_run    = 1;
  endtask

  task automatic model_step(input logic rst, input logic [3:0] r);
    if (rst) begin
      m_holder = -1; m_last = 3; m_sel = 0; m_run = 0;
    end else if (m_holder < 0) begin
      if (r != 4'b0000) model_grant(next_from(r, (m_last + 1) % 4));
    end else if (!r[m_holder]) begin
      if (r != 4'b0000) model_grant(next_from(r, (m_holder + 1) % 4));
      else begin
        m_holder = -1; m_run = 0;
      end
    end else begin
`ifdef ARB4_QUANTUM_EN
      if (m_run == QUANTUM) begin
        if ((r & ~(4'b0001 << m_holder)) != 4'b0000) model_grant(next_from(r, (m_holder + 1) % 4));
        else m_run = 1;
      end else begin
        m_run++;
      end
`else
      m_run++;
`endif
    end
  endtask

  function automatic logic [3:0] model_gnt();
    return (m_holder < 0) ? 4'b0000 : (4'b0001 << m_holder);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic [3:0] r);
    @(negedge clk);
    reset = rst;
    req   = r;
    @(posedge clk);
    model_step(rst, r);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_gnt"}, gnt, model_gnt());
    check({tag, "_sel"}, {2'b00, sel}, 4'(m_sel));
    check({tag, "_busy"}, {3'b000, busy}, {3'b000, m_holder >= 0});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] r, input logic [3:0] g,
                     input logic [1:0] s, input logic b);
    vec_t v;
    v.rst = rst; v.req = r; v.gnt = g; v.sel = s; v.busy = b;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    m_holder = -1; m_last = 3; m_sel = 0; m_run = 0;

    // reset state, two-requester handoff, sole requester re-grant
    add(1, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0101, 4'b0001, 2'd0, 1);
    add(0, 4'b0101, 4'b0001, 2'd0, 1);
    add(0, 4'b0100, 4'b0100, 2'd2, 1);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 1);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    // full rotation 0,1,2,3,0 with every holder keeping 2 cycles
    add(1, 4'b1111, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 1);
    add(0, 4'b1111, 4'b0001, 2'd0, 1);
    add(0, 4'b1110, 4'b0010, 2'd1, 1);
    add(0, 4'b1110, 4'b0010, 2'd1, 1);
    add(0, 4'b1100, 4'b0100, 2'd2, 1);
    add(0, 4'b1100, 4'b0100, 2'd2, 1);
    add(0, 4'b1000, 4'b1000, 2'd3, 1);
    add(0, 4'b1000, 4'b1000, 2'd3, 1);
    add(0, 4'b0111, 4'b0001, 2'd0, 1);
    add(0, 4'b0111, 4'b0001, 2'd0, 1);
    add(0, 4'b0100, 4'b0100, 2'd2, 1);
    // reset mid-grant, then restart from requester 0
    add(1, 4'b1111, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 1);
    // wrap 3->0 during the search
    add(0, 4'b1000, 4'b1000, 2'd3, 1);
    add(0, 4'b0010, 4'b0010, 2'd1, 1);
    add(0, 4'b0000, 4'b0000, 2'd1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req);
      check($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      check($sformatf("vec%0d_sel", i), {2'b00, sel}, {2'b00, vecs[i].sel});
      check($sformatf("vec%0d_busy", i), {3'b000, busy}, {3'b000, vecs[i].busy});
    end

    // grant to 2, then a one-cycle reset pulse with every request up
    drive(1, 4'b0000);
    drive(0, 4'b0100);
    check("rst_pulse_pre_sel", {2'b00, sel}, 4'd2);
    drive(1, 4'b1111);
    check("rst_pulse_gnt", gnt, 4'b0000);
    drive(0, 4'b1111);
    check("rst_pulse_after_gnt", gnt, 4'b0001);
    check("rst_pulse_after_sel", {2'b00, sel}, 4'd0);

`ifdef ARB4_QUANTUM_EN
    // two contenders alternate every QUANTUM cycles
    drive(1, 4'b0000);
    for (int k = 0; k < 4 * QUANTUM; k++) begin
      drive(0, 4'b0011);
      check($sformatf("quantum_alt%0d", k), gnt, ((k / QUANTUM) % 2) ? 4'b0010 : 4'b0001);
    end
    // a lone holder keeps the grant across the quantum boundary
    drive(1, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      drive(0, 4'b1000);
      check($sformatf("quantum_sole%0d", k), gnt, 4'b1000);
    end
`else
    // without the quantum a holder keeps the grant indefinitely
    drive(1, 4'b0000);
    for (int k = 0; k < 20; k++) begin
      drive(0, 4'b0011);
      check($sformatf("noquantum_hold%0d", k), gnt, 4'b0001);
    end
    drive(0, 4'b0010);
    check("noquantum_release", gnt, 4'b0010);
`endif

    // randomized traffic against the model, with occasional resets
    drive(1, 4'b0000);
    for (int k = 0; k < 3000; k++) begin
      logic       rst_r;
      logic [3:0] r;
      rst_r = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      else r = req;
      if ($urandom_range(0, 7) == 0) r = 4'b0000;
      drive(rst_r, r);
      check_model($sformatf("rand%0d", k));
      checks++;
      if (!((gnt & (gnt - 4'd1)) == 4'b0000 && busy == |gnt)) begin
        errors++;
        $display("FAIL rand%0d_onehot: gnt %b busy %b", k, gnt, busy);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbiter_4way.md
ARBITER_4WAY -- requirements
Module: arbiter_4way

Interface
REQ-001 SHALL have parameter QUANTUM, default 4, maximum consecutive grant cycles per holder when ARB4_QUANTUM_EN is defined; legal range 1..15.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  4  request per requester; req[i] drives Mux4Way data input i (a=0, b=1, c=2, d=3).
REQ-005 SHALL have port gnt  output  4  one-hot grant, registered.
REQ-006 SHALL have port sel  output  2  binary index of current or last holder, wired directly to Mux4Way sel.
REQ-007 SHALL have port busy  output  1  high while any gnt bit is high.

Function
REQ-008 SHALL implement two states: IDLE (gnt=0000) and GRANT (exactly one gnt bit high).
REQ-009 SHALL keep gnt zero-or-one-hot in every cycle; busy SHALL equal OR of gnt.
REQ-010 SHALL use registered outputs: req sampled at edge N affects gnt/sel/busy after edge N, never combinationally.
REQ-011 IDLE->GRANT: at the edge where req != 0000, grant the first asserted requester in round-robin order starting at (ptr+1) mod 4.
REQ-012 SHALL hold ptr, a 2-bit register holding the last granted index; ptr updates to i on each new grant to i.
REQ-013 GRANT hold: holder i keeps the grant while req[i]=1, subject to REQ-016.
REQ-014 GRANT release: at the edge where req[i]=0, grant the next requester in round-robin order from (i+1) mod 4 if any req is high, with no idle cycle; otherwise go to IDLE.
REQ-015 sel SHALL equal the index of the high gnt bit in GRANT and SHALL hold ptr in IDLE.
REQ-016 With ARB4_QUANTUM_EN defined: a 4-bit counter SHALL count the holder's granted cycles (1 on the first grant cycle). When the count equals QUANTUM and another req is high, grant SHALL rotate to the next requester per REQ-014 at that edge. When no other req is high, the holder SHALL keep the grant and the counter SHALL restart at 1.
REQ-017 The counter SHALL reload to 1 on every new grant and hold 0 in IDLE.
REQ-018 Rotation search SHALL wrap 3->0; a sole requester SHALL be re-granted after release if it reasserts, with one IDLE cycle between.
REQ-019 req changes on non-holders SHALL never alter the current grant except via REQ-016.

Reset
REQ-020 SHALL, when reset=1 at an edge, set state=IDLE, gnt=0000, busy=0, ptr=3, sel=0 and counter=0; reset SHALL take priority over all requests.
REQ-021 Reset asserted mid-grant SHALL drop gnt to 0000 at that edge; after reset deasserts, arbitration SHALL restart from requester 0.
REQ-022 sel SHALL read 0 after reset despite ptr=3; sel SHALL follow ptr from the first grant onward.

Configuration
REQ-023 Macro ARB4_QUANTUM_EN defined: REQ-016 and REQ-017 are in effect and the quantum counter is present.
REQ-024 Macro ARB4_QUANTUM_EN undefined: no counter exists, QUANTUM is ignored, and the holder keeps the grant until it drops req.

Verification
REQ-025 Reset then req=0101 held -> gnt=0001, sel=0 one cycle later; drop req[0] -> next cycle gnt=0100, sel=2, busy stays 1.
REQ-026 req=1111 with each holder dropping req after 2 cycles -> grant order 0,1,2,3,0 with no idle cycles.
REQ-027 ARB4_QUANTUM_EN, QUANTUM=4, req=0011 held constant -> gnt=0001 for 4 cycles, then 0010 for 4 cycles, alternating.
REQ-028 ARB4_QUANTUM_EN, QUANTUM=4, only req=1000 held 10 cycles -> gnt=1000 throughout; no glitch at count 4.
REQ-029 Grant to 2 with sel=2, then pulse reset 1 cycle with req=1111 -> gnt=0000 at the reset edge, then gnt=0001, sel=0.
REQ-030 No macro, req=0011 held 20 cycles -> gnt=0001 for all 20 cycles; drop req[0] -> gnt=0010 next cycle.
